// File: rtl/memory_port.sv
// Memory-side responder: turns one peek/poke request at a time into
// accesses on a synchronous single-port RAM and returns the word read
// (pre-write contents for a poke) on the response channel.
module memory_port #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MEM_SEND_ADDR_VALID,
  input  logic [31:0]           MEM_SEND_ADDR,
  input  logic                  MEM_SEND_DATA_VALID,
  input  logic [31:0]           MEM_SEND_DATA,
  output logic                  MEM_SEND_READY,
  output logic                  MEM_RECEIVE_VALID,
  output logic [31:0]           MEM_RECEIVE_DATA,
  input  logic                  MEM_RECEIVE_READY,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA
);

  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  logic [2:0]            state_q,      state_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [DATA_WIDTH-1:0] wbuf_q,       wbuf_d;
  logic                  is_poke_q,    is_poke_d;
  logic [CNT_W-1:0]      cnt_q,        cnt_d;
  logic                  send_ready_q, send_ready_d;
  logic                  recv_valid_q, recv_valid_d;
  logic [31:0]           recv_data_q,  recv_data_d;
  logic                  ram_en_q,     ram_en_d;
  logic                  ram_we_q,     ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;

  // Upper request address bits are deliberately dropped (address wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^MEM_SEND_ADDR[31:ADDR_WIDTH];

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wbuf_q       <= '0;
      is_poke_q    <= 1'b0;
      cnt_q        <= '0;
      send_ready_q <= 1'b0;
      recv_valid_q <= 1'b0;
      recv_data_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wbuf_q       <= wbuf_d;
      is_poke_q    <= is_poke_d;
      cnt_q        <= cnt_d;
      send_ready_q <= send_ready_d;
      recv_valid_q <= recv_valid_d;
      recv_data_q  <= recv_data_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  // Next-state and next-output logic; RAM strobes are single-cycle pulses.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wbuf_d       = wbuf_q;
    is_poke_d    = is_poke_q;
    cnt_d        = cnt_q;
    send_ready_d = send_ready_q;
    recv_valid_d = recv_valid_q;
    recv_data_d  = recv_data_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        send_ready_d = 1'b1;
        // Only an advertised READY counts as an accept; DATA_VALID alone is ignored.
        if (MEM_SEND_ADDR_VALID && send_ready_q) begin
          addr_d       = MEM_SEND_ADDR[ADDR_WIDTH-1:0];
          wbuf_d       = DATA_WIDTH'(MEM_SEND_DATA);
          is_poke_d    = MEM_SEND_DATA_VALID;
          send_ready_d = 1'b0;
          ram_en_d     = 1'b1;
          ram_we_d     = 1'b0;
          ram_addr_d   = MEM_SEND_ADDR[ADDR_WIDTH-1:0];
          state_d      = ST_READ;
        end
      end

      ST_READ: begin
        // Read strobe is on the bus this cycle; start the latency countdown.
        cnt_d   = CNT_W'(READ_LATENCY);
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          recv_data_d = 32'(RAM_RDATA);
          if (is_poke_q) begin
            // Write the new word before responding so later peeks see it.
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = addr_q;
            ram_wdata_d = wbuf_q;
            state_d     = ST_WRITE;
          end else begin
            recv_valid_d = 1'b1;
            state_d      = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WRITE: begin
        recv_valid_d = 1'b1;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        // Response data is held until the consumer takes it.
        if (MEM_RECEIVE_READY) begin
          recv_valid_d = 1'b0;
          send_ready_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        send_ready_d = 1'b0;
        recv_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  assign MEM_SEND_READY    = send_ready_q;
  assign MEM_RECEIVE_VALID = recv_valid_q;
  assign MEM_RECEIVE_DATA  = recv_data_q;
  assign RAM_EN            = ram_en_q;
  assign RAM_WE            = ram_we_q;
  assign RAM_ADDR          = ram_addr_q;
  assign RAM_WDATA         = ram_wdata_q;

endmodule

// File: tb/tb_memory_port.sv
// Scoreboard bench for memory_port: instance 0 uses READ_LATENCY=1,
// instance 1 uses READ_LATENCY=3, each behind its own behavioural RAM.
module tb_memory_port;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;

  logic          av [2];
  logic          dv [2];
  logic [31:0]   saddr [2];
  logic [31:0]   sdata [2];
  logic          srdy [2];
  logic          rv [2];
  logic [31:0]   rdata_o [2];
  logic          rrdy [2];
  logic          ren [2];
  logic          rwe [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];

  always #5 clk = ~clk;

  memory_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut_l1 (
    .CLK(clk), .RST(rst_n),
    .MEM_SEND_ADDR_VALID(av[0]), .MEM_SEND_ADDR(saddr[0]),
    .MEM_SEND_DATA_VALID(dv[0]), .MEM_SEND_DATA(sdata[0]),
    .MEM_SEND_READY(srdy[0]),
    .MEM_RECEIVE_VALID(rv[0]), .MEM_RECEIVE_DATA(rdata_o[0]),
    .MEM_RECEIVE_READY(rrdy[0]),
    .RAM_EN(ren[0]), .RAM_WE(rwe[0]), .RAM_ADDR(ram_addr[0]),
    .RAM_WDATA(ram_wdata[0]), .RAM_RDATA(ram_rdata[0])
  );

  memory_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3)) dut_l3 (
    .CLK(clk), .RST(rst_n),
    .MEM_SEND_ADDR_VALID(av[1]), .MEM_SEND_ADDR(saddr[1]),
    .MEM_SEND_DATA_VALID(dv[1]), .MEM_SEND_DATA(sdata[1]),
    .MEM_SEND_READY(srdy[1]),
    .MEM_RECEIVE_VALID(rv[1]), .MEM_RECEIVE_DATA(rdata_o[1]),
    .MEM_RECEIVE_READY(rrdy[1]),
    .RAM_EN(ren[1]), .RAM_WE(rwe[1]), .RAM_ADDR(ram_addr[1]),
    .RAM_WDATA(ram_wdata[1]), .RAM_RDATA(ram_rdata[1])
  );

  // Behavioural RAMs with a read pipeline, plus a backdoor preload port.
  logic [31:0] mem [2][65536];
  logic [31:0] pipe [2][4];
  logic        pl_en;
  logic        pl_k;
  logic [15:0] pl_addr;
  logic [31:0] pl_data;
  int          en_cnt [2];
  int          we_cnt [2];
  logic [15:0] last_rd_addr [2];
  logic [15:0] last_wr_addr [2];
  logic [31:0] last_wdata [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ren[k] && !rwe[k]) begin
        pipe[k][0]      <= mem[k][ram_addr[k]];
        last_rd_addr[k] <= ram_addr[k];
      end
      if (ren[k]) en_cnt[k] <= en_cnt[k] + 1;
      if (rwe[k]) we_cnt[k] <= we_cnt[k] + 1;
      if (ren[k] && rwe[k]) begin
        mem[k][ram_addr[k]] <= ram_wdata[k];
        last_wr_addr[k]     <= ram_addr[k];
        last_wdata[k]       <= ram_wdata[k];
      end
      for (int i = 1; i < 4; i++) pipe[k][i] <= pipe[k][i-1];
    end
    if (pl_en) mem[pl_k][pl_addr] <= pl_data;
  end

  assign ram_rdata[0] = pipe[0][0];
  assign ram_rdata[1] = pipe[1][2];

  // Reference contents and expected-response queues.
  logic [31:0] ref_mem [2][65536];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int n_cmp;
  int n_fail;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic preload(input int k, input logic [15:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_k    = k[0];
    pl_addr = a;
    pl_data = d;
    ref_mem[k][a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Present a request until accepted; waits = edges until the accept edge.
  task automatic issue(input int k, input logic [31:0] a, input logic poke,
                       input logic [31:0] d, input bit track, output int waits);
    bit was;
    int n;
    logic [15:0] a16;
    a16      = a[15:0];
    av[k]    = 1'b1;
    saddr[k] = a;
    dv[k]    = poke;
    sdata[k] = d;
    n = 0;
    do begin
      was = srdy[k];
      @(posedge clk); #1;
      n++;
    end while (!was && n < 60);
    av[k] = 1'b0;
    dv[k] = 1'b0;
    if (!was) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else if (track) begin
      if (k == 0) exp_q0.push_back(ref_mem[k][a16]);
      else        exp_q1.push_back(ref_mem[k][a16]);
      if (poke) ref_mem[k][a16] = d;
    end
    waits = n;
  endtask

  // Edges to first VALID, counting the accept edge as edge 1.
  task automatic wait_valid(input int k, output int n);
    n = 1;
    while (!rv[k] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rv[k]) check("valid_timeout", 32'd0, 32'd1);
  endtask

  // Pops and compares on every completed response handshake.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (rv[0] && rrdy[0]) begin
          if (exp_q0.size() == 0) check("resp0_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q0.pop_front();
            check("resp0_data", rdata_o[0], e);
          end
        end
        if (rv[1] && rrdy[1]) begin
          if (exp_q1.size() == 0) check("resp1_unexpected", 32'd1, 32'd0);
          else begin
            e = exp_q1.pop_front();
            check("resp1_data", rdata_o[1], e);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int w;
    int n;
    int e0;
    int w0;
    n_cmp  = 0;
    n_fail = 0;
    pl_en  = 1'b0;
    pl_k   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    rst_n  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      av[k] = 1'b1; dv[k] = 1'b0; saddr[k] = 32'h10; sdata[k] = '0; rrdy[k] = 1'b1;
    end
    fork
      monitor();
    join_none

    // Reset with a request pending; preload RAMs meanwhile.
    repeat (3) @(posedge clk);
    #1;
    preload(0, 16'h0010, 32'hDEAD_BEEF);
    preload(0, 16'h0011, 32'hCAFE_F00D);
    preload(1, 16'h0002, 32'hA5A5_0002);
    preload(1, 16'h0003, 32'h1111_0003);
    preload(1, 16'h0030, 32'h7777_0030);
    for (int i = 0; i < 16; i++) begin
      preload(0, 16'h0020 + 16'(i), $urandom);
      preload(1, 16'h0020 + 16'(i), $urandom);
    end
    check("rst_send_ready", srdy[0], 32'd0);
    check("rst_ram_en", ren[0], 32'd0);
    check("rst_recv_valid", rv[0], 32'd0);
    check("rst_send_ready_l3", srdy[1], 32'd0);
    av[0] = 1'b0; av[1] = 1'b0;
    rst_n = 1'b1;
    check("rel_ready_same_cycle", srdy[0], 32'd0);
    @(posedge clk); #1;
    check("rel_ready_next", srdy[0], 32'd1);
    check("rel_ready_next_l3", srdy[1], 32'd1);

    // Peek, latency 1.
    e0 = en_cnt[0]; w0 = we_cnt[0];
    issue(0, 32'h0000_0010, 1'b0, 32'h0, 1'b1, w);
    wait_valid(0, n);
    check("peek_latency", n, 32'd3);
    check("peek_data_now", rdata_o[0], 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("peek_valid_one_cycle", rv[0], 32'd0);
    check("peek_en_count", en_cnt[0] - e0, 32'd1);
    check("peek_we_count", we_cnt[0] - w0, 32'd0);
    check("peek_ram_addr", last_rd_addr[0], 32'h10);

    // Poke over DEADBEEF, then peek back.
    e0 = en_cnt[0]; w0 = we_cnt[0];
    issue(0, 32'h0000_0010, 1'b1, 32'h1234_5678, 1'b1, w);
    wait_valid(0, n);
    check("poke_latency", n, 32'd4);
    @(posedge clk); #1;
    check("poke_valid_one_cycle", rv[0], 32'd0);
    check("poke_en_count", en_cnt[0] - e0, 32'd2);
    check("poke_we_count", we_cnt[0] - w0, 32'd1);
    check("poke_wr_addr", last_wr_addr[0], 32'h10);
    check("poke_wdata", last_wdata[0], 32'h1234_5678);
    issue(0, 32'h0000_0010, 1'b0, 32'h0, 1'b1, w);
    wait_valid(0, n);
    @(posedge clk); #1;

    // Backpressure: 5 cycles held in RESP with a new request waiting.
    rrdy[0] = 1'b0;
    issue(0, 32'h0000_0011, 1'b0, 32'h0, 1'b1, w);
    wait_valid(0, n);
    e0 = en_cnt[0];
    av[0] = 1'b1; saddr[0] = 32'h10; dv[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rv[0], 32'd1);
      check("bp_data", rdata_o[0], 32'hCAFE_F00D);
      check("bp_send_ready", srdy[0], 32'd0);
      @(posedge clk); #1;
    end
    check("bp_no_ram_access", en_cnt[0] - e0, 32'd0);
    rrdy[0] = 1'b1;
    issue(0, 32'h0000_0010, 1'b0, 32'h0, 1'b1, w);
    check("bp_next_accept_edges", w, 32'd2);
    wait_valid(0, n);
    @(posedge clk); #1;

    // Latency 3 with address wrap.
    issue(1, 32'hFFFF_0002, 1'b0, 32'h0, 1'b1, w);
    wait_valid(1, n);
    check("l3_peek_latency", n, 32'd5);
    check("l3_wrap_addr", last_rd_addr[1], 32'h0002);
    @(posedge clk); #1;
    issue(1, 32'h0001_0003, 1'b1, 32'h0BAD_F00D, 1'b1, w);
    wait_valid(1, n);
    check("l3_poke_latency", n, 32'd6);
    @(posedge clk); #1;
    check("l3_poke_wr_addr", last_wr_addr[1], 32'h0003);
    issue(1, 32'h0000_0003, 1'b0, 32'h0, 1'b1, w);

    // Random poke/peek pairs on both instances.
    for (int it = 0; it < 200; it++) begin
      int k;
      logic [31:0] a;
      k = it % 2;
      a = {16'($urandom), 12'h002, 4'($urandom)};
      issue(k, a, 1'b1, $urandom, 1'b1, w);
      a = {16'($urandom), 12'h002, 4'($urandom)};
      issue(k, a, 1'b0, 32'h0, 1'b1, w);
    end
    repeat (12) @(posedge clk);
    #1;

    // Reset in the WAIT phase of a poke: no write, no response.
    w0 = we_cnt[1];
    issue(1, 32'h0000_0030, 1'b1, 32'h5555_5555, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ram_en", ren[1], 32'd0);
    check("midrst_valid", rv[1], 32'd0);
    check("midrst_ready", srdy[1], 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_we", we_cnt[1] - w0, 32'd0);
    issue(1, 32'h0000_0030, 1'b0, 32'h0, 1'b1, w);
    repeat (12) @(posedge clk);
    #1;

    check("q0_drained", exp_q0.size(), 32'd0);
    check("q1_drained", exp_q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
